// File: rtl/gbc_pkg.sv
// Shared constants and types for the GBC VRAM DMA controller (FF51-FF55).
package gbc_pkg;

    localparam logic [15:0] HDMA_BASE_DEF  = 16'hff51;
    localparam logic [2:0]  HDMA1_OFS      = 3'd0;
    localparam logic [2:0]  HDMA2_OFS      = 3'd1;
    localparam logic [2:0]  HDMA3_OFS      = 3'd2;
    localparam logic [2:0]  HDMA4_OFS      = 3'd3;
    localparam logic [2:0]  HDMA5_OFS      = 3'd4;
    localparam int          BLOCK_BYTES_DEF = 16;
    localparam logic [6:0]  REMAINING_IDLE = 7'h7f;

    typedef enum logic [2:0] {
        IDLE,
        GDMA_RD,
        GDMA_WR,
        HARM,
        HDMA_RD,
        HDMA_WR
    } hdma_state_t;

endpackage

// File: rtl/hdma_xfer.sv
// Two-cycle byte mover: read from src_ctr, write the latched byte to VRAM at dst_ctr.
// i_start loads the counters; o_done flags the last byte of a block (meaningful in a WR cycle).
module hdma_xfer
    import gbc_pkg::*;
#(
    parameter int BLOCK_BYTES = BLOCK_BYTES_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_start,
    input  logic [15:0] i_src,
    input  logic [12:0] i_dst,
    input  logic        i_rd,
    input  logic        i_wr,
    input  logic [7:0]  i_m_indata,
    output logic [15:0] o_m_address,
    output logic [7:0]  o_m_outdata,
    output logic        o_m_load,
    output logic        o_m_store,
    output logic        o_done
);

    localparam int               IDX_W    = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);

    logic [15:0]      r_src_ctr;
    logic [12:0]      r_dst_ctr;
    logic [IDX_W-1:0] r_byte_idx;
    logic [7:0]       r_data;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_src_ctr  <= 16'h0000;
            r_dst_ctr  <= 13'h0000;
            r_byte_idx <= '0;
            r_data     <= 8'h00;
        end else if (i_start) begin
            r_src_ctr  <= i_src;
            r_dst_ctr  <= i_dst;
            r_byte_idx <= '0;
        end else begin
            if (i_rd) begin
                r_data <= i_m_indata;
            end
            if (i_wr) begin
                r_src_ctr  <= r_src_ctr + 16'd1;
                r_dst_ctr  <= r_dst_ctr + 13'd1;
                r_byte_idx <= (r_byte_idx == LAST_IDX) ? '0 : r_byte_idx + IDX_W'(1);
            end
        end
    end

    // Destination stays inside 8000-9fff because only 13 bits are counted.
    always_comb begin
        o_m_address = 16'h0000;
        o_m_outdata = 8'h00;
        if (i_rd) begin
            o_m_address = r_src_ctr;
        end else if (i_wr) begin
            o_m_address = {3'b100, r_dst_ctr};
            o_m_outdata = r_data;
        end
    end

    assign o_m_load  = i_rd;
    assign o_m_store = i_wr;
    assign o_done    = (r_byte_idx == LAST_IDX);

endmodule

// File: rtl/hdma.sv
// GBC VRAM DMA controller: FF51-FF55 register decode plus the GDMA/HDMA sequencing FSM.
// While active is high the bus mux routes this block's m_* port to the shared bus.
module hdma
    import gbc_pkg::*;
#(
    parameter logic [15:0] BASE        = HDMA_BASE_DEF,
    parameter int          BLOCK_BYTES = BLOCK_BYTES_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [7:0]  indata,
    output logic [7:0]  outdata,
    input  logic        load,
    input  logic        store,
    input  logic        hblank,
    output logic [15:0] m_address,
    input  logic [7:0]  m_indata,
    output logic [7:0]  m_outdata,
    output logic        m_load,
    output logic        m_store,
    output logic        active
);

    hdma_state_t r_state;
    hdma_state_t w_next_state;
    logic [7:0]  r_src_hi;
    logic [3:0]  r_src_lo;
    logic [4:0]  r_dst_hi;
    logic [3:0]  r_dst_lo;
    logic [6:0]  r_remaining;
    logic [6:0]  w_next_remaining;
    logic        r_hblank_prev;

    logic [15:0] w_offset;
    logic        w_sel;
    logic        w_ff55_wr;
    logic        w_hblank_rise;
    logic        w_busy;
    logic        w_start;
    logic        w_rd;
    logic        w_wr;
    logic        w_done;

    assign w_offset      = address - BASE;
    assign w_sel         = (w_offset < 16'd5);
    assign w_ff55_wr     = store && w_sel && (w_offset[2:0] == HDMA5_OFS);
    assign w_hblank_rise = hblank && !r_hblank_prev;
    assign w_busy        = (r_state != IDLE);

    // Only the address bits that feed src/dst are kept; the rest read back as 1s anyway.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_src_hi      <= 8'h00;
            r_src_lo      <= 4'h0;
            r_dst_hi      <= 5'h00;
            r_dst_lo      <= 4'h0;
            r_hblank_prev <= 1'b0;
        end else begin
            r_hblank_prev <= hblank;
            if (store && w_sel) begin
                case (w_offset[2:0])
                    HDMA1_OFS: r_src_hi <= indata;
                    HDMA2_OFS: r_src_lo <= indata[7:4];
                    HDMA3_OFS: r_dst_hi <= indata[4:0];
                    HDMA4_OFS: r_dst_lo <= indata[7:4];
                    default:   ;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_remaining <= REMAINING_IDLE;
        end else begin
            r_state     <= w_next_state;
            r_remaining <= w_next_remaining;
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        w_next_state     = r_state;
        w_next_remaining = r_remaining;
        w_start          = 1'b0;
        w_rd             = 1'b0;
        w_wr             = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ff55_wr) begin
                    w_next_remaining = indata[6:0];
                    w_start          = 1'b1;
                    w_next_state     = indata[7] ? HARM : GDMA_RD;
                end
            end
            HARM: begin
                if (w_ff55_wr) begin
                    if (indata[7]) begin
                        w_next_remaining = indata[6:0];
                        w_start          = 1'b1;
                    end else begin
                        w_next_state = IDLE;
                    end
                end else if (w_hblank_rise) begin
                    w_next_state = HDMA_RD;
                end
            end
            GDMA_RD: begin
                w_rd         = 1'b1;
                w_next_state = GDMA_WR;
            end
            GDMA_WR: begin
                w_wr         = 1'b1;
                w_next_state = GDMA_RD;
                if (w_done) begin
                    if (r_remaining == 7'd0) begin
                        w_next_state     = IDLE;
                        w_next_remaining = REMAINING_IDLE;
                    end else begin
                        w_next_remaining = r_remaining - 7'd1;
                    end
                end
            end
            HDMA_RD: begin
                w_rd         = 1'b1;
                w_next_state = HDMA_WR;
            end
            HDMA_WR: begin
                w_wr         = 1'b1;
                w_next_state = HDMA_RD;
                if (w_done) begin
                    if (r_remaining == 7'd0) begin
                        w_next_state     = IDLE;
                        w_next_remaining = REMAINING_IDLE;
                    end else begin
                        w_next_state     = HARM;
                        w_next_remaining = r_remaining - 7'd1;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        outdata = 8'h00;
        if (load && w_sel) begin
            outdata = (w_offset[2:0] == HDMA5_OFS) ? {~w_busy, r_remaining} : 8'hff;
        end
    end

    assign active = w_rd || w_wr;

    hdma_xfer #(
        .BLOCK_BYTES (BLOCK_BYTES)
    ) u_xfer (
        .clock       (clock),
        .reset       (reset),
        .i_start     (w_start),
        .i_src       ({r_src_hi, r_src_lo, 4'h0}),
        .i_dst       ({r_dst_hi, r_dst_lo, 4'h0}),
        .i_rd        (w_rd),
        .i_wr        (w_wr),
        .i_m_indata  (m_indata),
        .o_m_address (m_address),
        .o_m_outdata (m_outdata),
        .o_m_load    (m_load),
        .o_m_store   (m_store),
        .o_done      (w_done)
    );

endmodule
